// File: rtl/button_event_pkg.sv
// Shared state encodings and constants for button_event_decoder.
package button_event_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_LONG   = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_PRESS2 = 3'd4;

    localparam int unsigned PULSE_W = 1;

    function automatic logic is_held(input logic [2:0] st);
        return (st == ST_PRESS1) || (st == ST_LONG) || (st == ST_PRESS2);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Previous-sample register and rise/fall detection for the debounced button level.
// The register tracks inp through reset, so a button held across reset release yields no edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic rise,
    output logic fall
);

    logic inp_q;

    always_ff @(posedge clk) begin
        inp_q <= inp;
    end

    assign rise = rst &  inp & ~inp_q;
    assign fall = rst & ~inp &  inp_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced presses into click / double click / long press strobes.
// Optional auto-repeat while long-held is enabled by defining AUTO_REPEAT_EN.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES       = 50_000_000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 12_500_000,
    parameter int unsigned REPEAT_CYCLES     = 5_000_000,
    parameter int unsigned CNT_W             = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic dbl_click_p,
    output logic long_p,
    output logic held,
    output logic repeat_p
);

    if (LONG_CYCLES < 2 || DOUBLE_GAP_CYCLES < 1 || REPEAT_CYCLES < 1 || PULSE_W != 1) begin : g_cfg_bad
        $error("button_event_decoder: illegal parameter set");
    end

    // PRESS1 is entered on the rising sample, so the terminal compare is two short of LONG.
    // GAP is entered on the falling sample; only low samples seen while in GAP count.
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

    logic             rise;
    logic             fall;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_inc;
    logic             long_hit;
    logic             click_hit;
    logic             dbl_hit;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .inp  (inp),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        long_hit  = 1'b0;
        click_hit = 1'b0;
        dbl_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_nxt = ST_GAP;
                end else if (inp) begin
                    if (cnt == LONG_TERM) begin
                        state_nxt = ST_LONG;
                        long_hit  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_LONG: begin
                if (fall) state_nxt = ST_IDLE;
            end
            ST_GAP: begin
                if (rise) begin
                    state_nxt = ST_PRESS2;
                    dbl_hit   = 1'b1;
                end else if (cnt == GAP_TERM) begin
                    state_nxt = ST_IDLE;
                    click_hit = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (cnt_inc) begin
            cnt_nxt = cnt + 1'b1;
        end else begin
            cnt_nxt = cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            press_p     <= 1'b0;
            release_p   <= 1'b0;
            click_p     <= 1'b0;
            dbl_click_p <= 1'b0;
            long_p      <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_p     <= rise;
            release_p   <= fall;
            click_p     <= click_hit;
            dbl_click_p <= dbl_hit;
            long_p      <= long_hit;
            held        <= is_held(state_nxt);
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rcnt;

    // rcnt is zero on entry to LONG, so the first repeat lands REPEAT_CYCLES after long_p.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt     <= '0;
            repeat_p <= 1'b0;
        end else begin
            repeat_p <= 1'b0;
            if (state == ST_LONG && inp) begin
                if (rcnt == REP_TERM) begin
                    rcnt     <= '0;
                    repeat_p <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end else begin
                rcnt <= '0;
            end
        end
    end
`else
    assign repeat_p = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomised bench for button_event_decoder: expected strobes are derived from
// run lengths of the recorded input sequence and compared every cycle.
module tb_button_event_decoder;

    localparam int LONG = 8;
    localparam int GAP  = 6;
    localparam int REP  = 4;
    localparam int MAXN = 3000;

    localparam int B_PRESS = 0;
    localparam int B_REL   = 1;
    localparam int B_CLICK = 2;
    localparam int B_DBL   = 3;
    localparam int B_LONG  = 4;
    localparam int B_HELD  = 5;
    localparam int B_REP   = 6;

    logic clk = 1'b0;
    logic rst;
    logic inp;
    logic press_p;
    logic release_p;
    logic click_p;
    logic dbl_click_p;
    logic long_p;
    logic held;
    logic repeat_p;

    logic       s_rst [MAXN];
    logic       s_inp [MAXN];
    logic [6:0] exp_v [MAXN];
    int         n_smp   = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    button_event_decoder #(
        .LONG_CYCLES       (LONG),
        .DOUBLE_GAP_CYCLES (GAP),
        .REPEAT_CYCLES     (REP),
        .CNT_W             (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inp         (inp),
        .press_p     (press_p),
        .release_p   (release_p),
        .click_p     (click_p),
        .dbl_click_p (dbl_click_p),
        .long_p      (long_p),
        .held        (held),
        .repeat_p    (repeat_p)
    );

    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (rep,held,long,dbl,click,rel,press)", tag, got, want);
        end
    endtask

    function automatic void add(input logic r, input logic v, input int len);
        for (int i = 0; i < len; i++) begin
            if (n_smp < MAXN) begin
                s_rst[n_smp] = r;
                s_inp[n_smp] = v;
                n_smp++;
            end
        end
    endfunction

    function automatic int run_len(input int k, input int e, input logic v);
        int n = 0;
        while (k + n < e && s_inp[k + n] == v) n++;
        return n;
    endfunction

    function automatic void mark(input int idx, input int e, input int b);
        if (idx < e) exp_v[idx][b] = 1'b1;
    endfunction

    // One reset-free stretch [b,e): walk press episodes by run length.
    function automatic void model_segment(input int b, input int e);
        int k = b;
        int h, f, l, r, h2;
        while (k < e) begin
            if (!(s_inp[k] && !s_inp[k - 1])) begin
                k++;
                continue;
            end
            h = run_len(k, e, 1'b1);
            f = k + h;
            for (int j = k; j < f; j++) mark(j, e, B_HELD);
            if (h >= LONG) begin
                mark(k + LONG - 1, e, B_LONG);
`ifdef AUTO_REPEAT_EN
                for (int m = 1; k + LONG - 1 + REP * m <= f - 1; m++)
                    mark(k + LONG - 1 + REP * m, e, B_REP);
`endif
                k = f + 1;
                continue;
            end
            if (f >= e) break;
            l = run_len(f, e, 1'b0);
            if (l - 1 >= GAP) begin
                mark(f + GAP, e, B_CLICK);
                k = f + GAP + 1;
                continue;
            end
            r = f + l;
            if (r >= e) break;
            mark(r, e, B_DBL);
            h2 = run_len(r, e, 1'b1);
            for (int j = r; j < r + h2; j++) mark(j, e, B_HELD);
            k = r + h2 + 1;
        end
    endfunction

    function automatic void build_expected();
        int k, b;
        for (int i = 0; i < n_smp; i++) exp_v[i] = '0;
        for (int i = 1; i < n_smp; i++) begin
            if (s_rst[i] && s_inp[i] && !s_inp[i - 1]) exp_v[i][B_PRESS] = 1'b1;
            if (s_rst[i] && !s_inp[i] && s_inp[i - 1]) exp_v[i][B_REL] = 1'b1;
        end
        k = 1;
        while (k < n_smp) begin
            if (!s_rst[k]) begin
                k++;
            end else begin
                b = k;
                while (k < n_smp && s_rst[k]) k++;
                model_segment(b, k);
            end
        end
    endfunction

    initial begin
        logic [6:0] got;
        rst = 1'b0;
        inp = 1'b0;

        add(0, 0, 3);  add(1, 0, 20);
        add(1, 1, 3);  add(1, 0, 10);
        add(1, 1, 3);  add(1, 0, 2);  add(1, 1, 3);  add(1, 0, 10);
        add(1, 1, 12); add(1, 0, 10);
        add(1, 1, 20); add(1, 0, 10);
        add(1, 1, 7);  add(1, 0, 10); add(1, 1, 8);  add(1, 0, 10);
        add(1, 1, 3);  add(1, 0, 6);  add(1, 1, 2);  add(1, 0, 10);
        add(1, 1, 3);  add(1, 0, 7);  add(1, 1, 2);  add(1, 0, 12);
        add(1, 1, 3);  add(1, 0, 2);  add(0, 0, 1);  add(1, 0, 10);
        add(1, 1, 12); add(0, 1, 1);  add(1, 1, 4);  add(1, 0, 10);
        add(0, 1, 3);  add(1, 1, 2);  add(1, 0, 2);  add(1, 1, 3);  add(1, 0, 10);
        while (n_smp < MAXN - 40) begin
            if ($urandom_range(0, 15) == 0) begin
                add(0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            end else begin
                add(1, 1, int'($urandom_range(1, 14)));
                add(1, 0, int'($urandom_range(1, 9)));
            end
        end
        add(1, 0, 20);

        build_expected();

        for (int k = 0; k < n_smp; k++) begin
            @(negedge clk);
            rst = s_rst[k];
            inp = s_inp[k];
            @(posedge clk);
            #1;
            got = {repeat_p, held, long_p, dbl_click_p, click_p, release_p, press_p};
            check_eq($sformatf("cyc%0d", k), got, exp_v[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
